// File: rtl/div_hilo_ctrl_if.sv
// Divider-side bus between div_hilo_ctrl (master) and the sign_div iterative divider (slave).
interface div_hilo_ctrl_if;
   logic [63:0] div_data;
   logic        div_enable;
   logic        div_rst;
   logic        div_busy;
   logic [63:0] div_result;

   modport master (
      output div_data,
      output div_enable,
      output div_rst,
      input  div_busy,
      input  div_result
   );

   modport slave (
      input  div_data,
      input  div_enable,
      input  div_rst,
      output div_busy,
      output div_result
   );
endinterface

// File: rtl/div_hilo_ctrl.sv
// DIV issue/writeback controller around sign_div: owns HI/LO, MTHI/MTLO, zero-divisor handling, hang watchdog.
// Optional macro DIV_ZERO_TRAP_EN: zero divisor raises div_zero_exc instead of the HI/LO bypass.
module div_hilo_ctrl #(
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned TIMEOUT    = 36
) (
   input  logic            clk_in,
   input  logic            reset,
   input  logic            div_start,
   input  logic [31:0]     rs_val,
   input  logic [31:0]     rt_val,
   input  logic            mthi_we,
   input  logic            mtlo_we,
   input  logic [31:0]     wdata,
   div_hilo_ctrl_if.master div_bus,
   output logic [31:0]     hi,
   output logic [31:0]     lo,
   output logic            stall,
   output logic            done,
   output logic            err
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic            div_zero_exc
`endif
);

   // A watchdog shorter than the divider would abort every divide, so clamp it just past DIV_CYCLES.
   localparam int unsigned TIMEOUT_EFF = (TIMEOUT > DIV_CYCLES) ? TIMEOUT : (DIV_CYCLES + 1);
   localparam int unsigned CNT_W       = $clog2(TIMEOUT_EFF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_WRITE  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [63:0]      op_r;
   logic [63:0]      op_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [31:0]      hi_r;
   logic [31:0]      hi_nxt_s;
   logic [31:0]      lo_r;
   logic [31:0]      lo_nxt_s;
   logic             enable_r;
   logic             enable_nxt_s;
   logic             done_r;
   logic             done_nxt_s;
   logic             err_r;
   logic             err_nxt_s;
   logic             div_rst_r;
   logic             div_rst_nxt_s;
`ifdef DIV_ZERO_TRAP_EN
   logic             exc_r;
   logic             exc_nxt_s;
`endif

   // Next-state and next-register-value logic for the issue/writeback FSM.
   always_comb begin
      state_nxt_s   = state_r;
      op_nxt_s      = op_r;
      cnt_nxt_s     = cnt_r;
      hi_nxt_s      = hi_r;
      lo_nxt_s      = lo_r;
      enable_nxt_s  = 1'b0;
      done_nxt_s    = 1'b0;
      err_nxt_s     = err_r;
      div_rst_nxt_s = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      exc_nxt_s     = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (mthi_we) begin
               hi_nxt_s = wdata;
            end else begin
               hi_nxt_s = hi_r;
            end
            if (mtlo_we) begin
               lo_nxt_s = wdata;
            end else begin
               lo_nxt_s = lo_r;
            end
            if (div_start) begin
               if (rt_val != 32'd0) begin
                  op_nxt_s     = {rs_val, rt_val};
                  enable_nxt_s = 1'b1;
                  state_nxt_s  = ST_LAUNCH;
               end else begin
`ifdef DIV_ZERO_TRAP_EN
                  exc_nxt_s    = 1'b1;
`else
                  // Zero divisor never reaches the divider: HI takes the dividend, LO saturates.
                  hi_nxt_s     = rs_val;
                  lo_nxt_s     = 32'hFFFF_FFFF;
                  done_nxt_s   = 1'b1;
`endif
                  state_nxt_s  = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            if (!div_bus.div_busy) begin
               state_nxt_s = ST_WRITE;
            end else if (cnt_r == CNT_LAST) begin
               // Divider hung: drop the operation, flag it and clear sign_div.
               state_nxt_s   = ST_IDLE;
               err_nxt_s     = 1'b1;
               div_rst_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_WRITE: begin
            hi_nxt_s    = div_bus.div_result[31:0];
            lo_nxt_s    = div_bus.div_result[63:32];
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; div_rst_r resets high so the divider stays cleared one clock past release.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         op_r      <= 64'd0;
         cnt_r     <= CNT_ZERO;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         enable_r  <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         div_rst_r <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
         exc_r     <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         op_r      <= op_nxt_s;
         cnt_r     <= cnt_nxt_s;
         hi_r      <= hi_nxt_s;
         lo_r      <= lo_nxt_s;
         enable_r  <= enable_nxt_s;
         done_r    <= done_nxt_s;
         err_r     <= err_nxt_s;
         div_rst_r <= div_rst_nxt_s;
`ifdef DIV_ZERO_TRAP_EN
         exc_r     <= exc_nxt_s;
`endif
      end
   end

   assign stall              = (state_r != ST_IDLE);
   assign hi                 = hi_r;
   assign lo                 = lo_r;
   assign done               = done_r;
   assign err                = err_r;
   assign div_bus.div_data   = op_r;
   assign div_bus.div_enable = enable_r;
   assign div_bus.div_rst    = div_rst_r;
`ifdef DIV_ZERO_TRAP_EN
   assign div_zero_exc       = exc_r;
`endif

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl with a behavioural sign_div stand-in on the divider bus.
module tb_div_hilo_ctrl;
   localparam int DIV_CYCLES = 32;
   localparam int TIMEOUT    = 36;

   logic        clk_in    = 1'b0;
   logic        reset     = 1'b0;
   logic        div_start = 1'b0;
   logic        mthi_we   = 1'b0;
   logic        mtlo_we   = 1'b0;
   logic [31:0] rs_val    = 32'd0;
   logic [31:0] rt_val    = 32'd0;
   logic [31:0] wdata     = 32'd0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall;
   logic        done;
   logic        err;
`ifdef DIV_ZERO_TRAP_EN
   logic        div_zero_exc;
`endif

   div_hilo_ctrl_if bus ();

   div_hilo_ctrl #(.DIV_CYCLES(DIV_CYCLES), .TIMEOUT(TIMEOUT)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .div_start (div_start),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .mthi_we   (mthi_we),
      .mtlo_we   (mtlo_we),
      .wdata     (wdata),
      .div_bus   (bus),
      .hi        (hi),
      .lo        (lo),
      .stall     (stall),
      .done      (done),
      .err       (err)
`ifdef DIV_ZERO_TRAP_EN
      ,
      .div_zero_exc (div_zero_exc)
`endif
   );

   always #5 clk_in = ~clk_in;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   bit          hang = 1'b0;
   int          busy_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sdiv(input logic [63:0] d);
      logic signed [31:0] a;
      logic signed [31:0] b;
      a = d[63:32];
      b = d[31:0];
      if (b == 32'sd0) return 64'd0;
      return {32'(a / b), 32'(a % b)};
   endfunction

   // sign_div stand-in: busy for DIV_CYCLES after load, reads operands again at completion.
   always @(posedge clk_in) begin
      if (bus.div_rst) begin
         busy_cnt     <= 0;
         bus.div_busy <= 1'b0;
      end else if (bus.div_enable) begin
         busy_cnt     <= DIV_CYCLES;
         bus.div_busy <= 1'b1;
      end else if (busy_cnt != 0 && !hang) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            bus.div_busy   <= 1'b0;
            bus.div_result <= sdiv(bus.div_data);
         end
      end
   end

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk_in) begin : monitor
      logic [63:0] e;
      if (reset && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with nothing pending, hi=%h lo=%h", hi, lo);
         end else begin
            e = exp_q.pop_front();
            check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
            check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit mt_same, input int mt_wait_cyc);
      int stall_bad = 0;
      int en_bad    = 0;
      int data_bad  = 0;
      int done_cyc  = -1;
      int done_cnt  = 0;
      @(negedge clk_in);
      div_start = 1'b1;
      rs_val    = a;
      rt_val    = b;
      if (mt_same) begin
         mthi_we = 1'b1;
         wdata   = 32'hDEAD_BEEF;
      end
      exp_q.push_back({exp_hi, exp_lo});
      for (int c = 1; c <= 38; c++) begin
         @(negedge clk_in);
         div_start = 1'b0;
         mthi_we   = 1'b0;
         mtlo_we   = 1'b0;
         rs_val    = 32'h0BAD_0BAD;
         rt_val    = 32'h0000_0000;
         if (mt_same && c == 1) check("mt_same_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
         if (mt_wait_cyc > 0 && c == mt_wait_cyc) begin
            mtlo_we = 1'b1;
            wdata   = 32'h5A5A_5A5A;
         end
         if (mt_wait_cyc > 0 && c == mt_wait_cyc + 1) check("mt_wait_lo", {32'd0, lo}, {32'd0, m_lo});
         if (stall !== (c <= 35)) stall_bad++;
         if (bus.div_enable !== (c == 1)) en_bad++;
         if (c <= 35 && bus.div_data !== {a, b}) data_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
      end
      check("stall_window_bad_cycles", 64'(stall_bad), 64'd0);
      check("div_enable_bad_cycles", 64'(en_bad), 64'd0);
      check("div_data_bad_cycles", 64'(data_bad), 64'd0);
      check("done_cycle", 64'(done_cyc), 64'd36);
      check("done_count", 64'(done_cnt), 64'd1);
      m_hi = exp_hi;
      m_lo = exp_lo;
   endtask

   initial begin : global_timeout
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int stall_bad;
      int en_bad;
      int done_cyc;
      int last_stall;
      int rst_cnt;
      int rst_cyc;
      int err_cyc;
      // Reset state
      @(negedge clk_in);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_flags_stall_done_err_en", {60'd0, stall, done, err, bus.div_enable}, 64'd0);
      check("rst_div_rst", {63'd0, bus.div_rst}, 64'd1);
      @(negedge clk_in);
      reset = 1'b1;
      #1 check("div_rst_after_release", {63'd0, bus.div_rst}, 64'd1);
      @(negedge clk_in);
      check("div_rst_cleared", {63'd0, bus.div_rst}, 64'd0);

      // Positive and signed divides
      run_div(32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 0);
      run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);

      // Zero divisor
      stall_bad = 0; en_bad = 0; done_cyc = -1;
      @(negedge clk_in);
      div_start = 1'b1;
      rs_val    = 32'h1234_5678;
      rt_val    = 32'd0;
`ifndef DIV_ZERO_TRAP_EN
      exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
`endif
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_in);
         div_start = 1'b0;
         if (stall !== 1'b0) stall_bad++;
         if (bus.div_enable !== 1'b0) en_bad++;
`ifdef DIV_ZERO_TRAP_EN
         if (div_zero_exc !== (c == 1)) done_cyc = 99;
`else
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
`endif
      end
      check("zero_stall_bad_cycles", 64'(stall_bad), 64'd0);
      check("zero_enable_bad_cycles", 64'(en_bad), 64'd0);
`ifdef DIV_ZERO_TRAP_EN
      check("zero_exc_pulse", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      check("zero_trap_hi", {32'd0, hi}, {32'd0, m_hi});
      check("zero_trap_lo", {32'd0, lo}, {32'd0, m_lo});
`else
      check("zero_done_cycle", 64'(done_cyc), 64'd1);
      m_hi = 32'h1234_5678;
      m_lo = 32'hFFFF_FFFF;
`endif

      // MTHI alone, then MTHI+MTLO together
      @(negedge clk_in);
      mthi_we = 1'b1;
      wdata   = 32'hA5A5_A5A5;
      @(negedge clk_in);
      mthi_we = 1'b0;
      check("mthi_hi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
      check("mthi_lo_untouched", {32'd0, lo}, {32'd0, m_lo});
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      wdata   = 32'h1357_9BDF;
      @(negedge clk_in);
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      check("mtboth_hi", {32'd0, hi}, {32'd0, 32'h1357_9BDF});
      check("mtboth_lo", {32'd0, lo}, {32'd0, 32'h1357_9BDF});
      m_hi = 32'h1357_9BDF;
      m_lo = 32'h1357_9BDF;

      // MTLO during WAIT is ignored; MTHI alongside div_start is overwritten by the result
      run_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 10);
      run_div(32'd20, 32'd3, 32'd2, 32'd6, 1'b1, 0);

      // Reset in the middle of a divide
      @(negedge clk_in);
      div_start = 1'b1;
      rs_val    = 32'd50;
      rt_val    = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_in);
         div_start = 1'b0;
      end
      reset = 1'b0;
      #1;
      check("midrst_stall", {63'd0, stall}, 64'd0);
      check("midrst_hi", {32'd0, hi}, 64'd0);
      check("midrst_lo", {32'd0, lo}, 64'd0);
      check("midrst_div_rst", {63'd0, bus.div_rst}, 64'd1);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk_in);
      reset = 1'b1;
      #1 check("midrst_div_rst_release", {63'd0, bus.div_rst}, 64'd1);
      @(negedge clk_in);
      check("midrst_div_rst_cleared", {63'd0, bus.div_rst}, 64'd0);
      run_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

      // Watchdog: divider never drops busy
      hang = 1'b1;
      last_stall = -1; rst_cnt = 0; rst_cyc = -1; err_cyc = -1;
      @(negedge clk_in);
      div_start = 1'b1;
      rs_val    = 32'd9;
      rt_val    = 32'd4;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk_in);
         div_start = 1'b0;
         if (stall === 1'b1) last_stall = c;
         if (bus.div_rst === 1'b1) begin
            rst_cnt++;
            rst_cyc = c;
         end
         if (err === 1'b1 && err_cyc < 0) err_cyc = c;
      end
      hang = 1'b0;
      check("wdog_last_stall_cycle", 64'(last_stall), 64'd37);
      check("wdog_err_cycle", 64'(err_cyc), 64'd38);
      check("wdog_div_rst_count", 64'(rst_cnt), 64'd1);
      check("wdog_div_rst_cycle", 64'(rst_cyc), 64'd38);
      check("wdog_hi", {32'd0, hi}, {32'd0, m_hi});
      check("wdog_lo", {32'd0, lo}, {32'd0, m_lo});

      // Normal divide after abort; err stays set
      run_div(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 0);
      check("err_sticky", {63'd0, err}, 64'd1);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Issue and writeback controller sitting directly upstream and downstream of the sign_div signed iterative divider in the CPU54 datapath.
- Accepts a DIV request from decode and freezes the operands for the divider.
- Launches sign_div and stalls the pipeline until the divider finishes, then writes quotient and remainder into the architectural HI/LO registers.
- Also owns MTHI/MTLO writes, the divide-by-zero bypass and a hang watchdog.

Parameters:
DIV_CYCLES, 32, divider iteration count (sign_div busy duration after load)
TIMEOUT, 36, max WAIT cycles before abort; must be > DIV_CYCLES

Ports:
clk_in  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
div_start  input  1  decode issues DIV this cycle (honoured only in IDLE)
rs_val  input  32  dividend
rt_val  input  32  divisor
mthi_we  input  1  write wdata to HI (honoured only in IDLE)
mtlo_we  input  1  write wdata to LO (honoured only in IDLE)
wdata  input  32  MTHI/MTLO data
div_data  output  64  to sign_div data_input: {dividend, divisor} from operand register
div_enable  output  1  to sign_div enable_signal, one-cycle pulse
div_rst  output  1  to sign_div reset, active-high
div_busy  input  1  from sign_div out
div_result  input  64  from sign_div out_data: [63:32] quotient, [31:0] remainder
hi  output  32  HI register
lo  output  32  LO register
stall  output  1  freeze fetch/decode
done  output  1  one-cycle pulse, HI/LO just updated by a DIV
err  output  1  sticky watchdog-abort flag
div_zero_exc  output  1  only with the optional feature; otherwise absent

Behaviour:
- Reset (reset low, async): state=IDLE; hi=0, lo=0, op register=0, counter=0; div_enable=0, done=0, err=0, div_zero_exc=0. div_rst=1 while reset is low and for the first clock after release (sync release), then 0.
- stall = (state != IDLE). Combinational from the state register only.
- div_data is driven from the operand register and held constant from accept until return to IDLE. sign_div re-reads its input at completion, so the operands must stay stable for that whole window.
- States: IDLE, LAUNCH, WAIT, WRITE.
- IDLE:
  - div_start=1 with rt_val!=0: latch {rs_val, rt_val}, go to LAUNCH.
  - div_start=1 with rt_val==0: zero bypass. hi<=rs_val, lo<=32'hFFFFFFFF, done=1 next cycle, stay in IDLE, no div_enable.
  - mthi_we/mtlo_we write hi/lo at this edge. Both may be set together.
  - An MT write in the same cycle as div_start is applied; the DIV result later overwrites it.
- LAUNCH: div_enable=1 for exactly this cycle; counter<=0; go to WAIT. sign_div loads at this edge and raises busy.
- WAIT:
  - Counter increments each cycle.
  - div_busy==0: go to WRITE.
  - Counter==TIMEOUT with busy still 1: go to IDLE, err<=1, div_rst=1 for one cycle, hi/lo unchanged.
- WRITE: hi<=div_result[31:0] (remainder), lo<=div_result[63:32] (quotient); done=1 next cycle; go to IDLE.
- Latency with DIV_CYCLES=32, counting the accept cycle as cycle 0:
  - LAUNCH in cycle 1; WAIT in cycles 2-33; busy low in cycle 34.
  - WRITE in cycle 35; hi/lo and done visible in cycle 36.
  - stall high in cycles 1-35.
- div_start, mthi_we and mtlo_we are ignored outside IDLE.
- err is cleared only by reset.
- Reset mid-operation: immediate return to IDLE, stall drops asynchronously, hi/lo=0, divider cleared via div_rst. No done pulse.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- Defined: a divisor of 0 in IDLE leaves hi/lo unchanged. div_zero_exc pulses high for one cycle (the cycle after accept), done stays 0, and no divider launch occurs.
- Undefined: the zero bypass above applies (HI=dividend, LO=all ones), and the div_zero_exc port does not exist.

Test Plan:
- Positive divide: rs=7, rt=2 -> div_enable pulse in cycle 1; hi=1, lo=3, done=1 in cycle 36; stall high exactly cycles 1-35.
- Signed divide: rs=32'hFFFFFFF9 (-7), rt=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); div_data constant throughout.
- Divide by zero, macro off: rs=32'h12345678, rt=0 -> hi=32'h12345678, lo=32'hFFFFFFFF, done in cycle 1, stall never high, div_enable never high. Macro on: div_zero_exc=1 in cycle 1, hi/lo unchanged.
- MT writes: mthi_we=1, wdata=32'hA5A5A5A5 in IDLE -> hi=A5A5A5A5 next cycle. mtlo_we during WAIT -> lo unchanged, and the final result is correct.
- Reset mid-divide: pull reset low in cycle 10 -> stall=0 and hi=lo=0 immediately; div_rst high until one clock after release; a new DIV of 100/7 afterwards gives lo=14, hi=2.
- Watchdog: hold div_busy=1 forever -> after 36 WAIT cycles state returns to IDLE, err=1 (sticky), div_rst pulses once, hi/lo unchanged, no done pulse.
